// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory between the CPU instruction
// and data ports. It grants one transaction at a time, alternates the grant
// when both ports contend, holds the last read data for each port, and raises
// a sticky bus_error when a granted access waits too long on the memory.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ip_address,
  input  logic        read_ip,
  output logic [31:0] ip_readdata,
  output logic        ip_waitrequest,
  input  logic [31:0] dp_address,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  input  logic        read_dp,
  input  logic        write_dp,
  output logic [31:0] dp_readdata,
  output logic        dp_waitrequest,
  output logic        stall,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  // Counter only needs to reach TIMEOUT_CYCLES; it saturates there.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nx;
  logic          last_data;   // 1 when the data port owned the most recent completed grant
  logic [31:0]   ip_hold, dp_hold;
  logic [CW-1:0] to_cnt;
  logic          ip_req, dp_req, dp_is_read, done;

  assign ip_req     = read_ip;
  assign dp_req     = read_dp | write_dp;
  // A simultaneous read and write is treated as a write; the read is dropped.
  assign dp_is_read = read_dp & ~write_dp;
  assign done       = (state != IDLE) && !mem_waitrequest;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: data wins contention unless it won last time.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (dp_req && (!ip_req || !last_data)) state_nx = GNT_D;
        else if (ip_req)                       state_nx = GNT_I;
      end
      GNT_I, GNT_D: if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory port drive for the current grant.
  always_comb begin
    mem_address    = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    mem_byteenable = '0;
    case (state)
      GNT_I: begin
        mem_address    = ip_address;
        mem_read       = 1'b1;
        mem_byteenable = 4'b1111;
      end
      GNT_D: begin
        mem_address    = dp_address;
        mem_read       = dp_is_read;
        mem_write      = write_dp;
        mem_writedata  = writedata;
        mem_byteenable = byteenable;
      end
      default: ;
    endcase
  end

  assign ip_waitrequest = ip_req & ~((state == GNT_I) & done);
  assign dp_waitrequest = dp_req & ~((state == GNT_D) & done);
  assign stall          = ip_waitrequest | dp_waitrequest;

  // Read data flows through in the completion cycle, otherwise comes from the hold register.
  assign ip_readdata = ((state == GNT_I) && done) ? mem_readdata : ip_hold;
  assign dp_readdata = ((state == GNT_D) && done && dp_is_read) ? mem_readdata : dp_hold;

  // Capture read data and remember who was served last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ip_hold   <= '0;
      dp_hold   <= '0;
      last_data <= 1'b0;
    end else if (done) begin
      last_data <= (state == GNT_D);
      if (state == GNT_I)               ip_hold <= mem_readdata;
      if (state == GNT_D && dp_is_read) dp_hold <= mem_readdata;
    end
  end

  // Wait-cycle counter for the active grant; the access keeps waiting after a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt    <= '0;
      bus_error <= 1'b0;
    end else if (state == IDLE || !mem_waitrequest) begin
      to_cnt <= '0;
    end else begin
      if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
      if (TIMEOUT_CYCLES != 0 && to_cnt == TO_LAST) bus_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of grants and memory contents.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ip_address, dp_address, writedata, mem_readdata;
  logic        read_ip, read_dp, write_dp, mem_waitrequest;
  logic [3:0]  byteenable;
  logic [31:0] ip_readdata, dp_readdata, mem_address, mem_writedata;
  logic        ip_waitrequest, dp_waitrequest, stall, mem_read, mem_write, bus_error;
  logic [3:0]  mem_byteenable;

  int checks = 0;
  int failures = 0;
  logic [31:0] mem_model [16];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ip_address(ip_address), .read_ip(read_ip), .ip_readdata(ip_readdata),
    .ip_waitrequest(ip_waitrequest),
    .dp_address(dp_address), .writedata(writedata), .byteenable(byteenable),
    .read_dp(read_dp), .write_dp(write_dp), .dp_readdata(dp_readdata),
    .dp_waitrequest(dp_waitrequest), .stall(stall),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
    .bus_error(bus_error)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    ip_address = '0; dp_address = '0; writedata = '0; byteenable = '0;
    read_ip = 0; read_dp = 0; write_dp = 0;
    mem_readdata = '0; mem_waitrequest = 0;
  endtask

  // Leaves time at posedge+1 with rst released and the DUT idle.
  task automatic do_reset;
    rst = 1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    clear_inputs();
    read_ip = 1;
    @(posedge clk);
    #2;
    checks++; if (ip_waitrequest !== 1'b1) begin failures++; $display("FAIL rst_ip_wait got=%b exp=1", ip_waitrequest); end
    checks++; if (dp_waitrequest !== 1'b0) begin failures++; $display("FAIL rst_dp_wait got=%b exp=0", dp_waitrequest); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rst_stall got=%b exp=1", stall); end
    checks++; if ({mem_read, mem_write, bus_error} !== 3'b000) begin failures++; $display("FAIL rst_strobes got=%b exp=000", {mem_read, mem_write, bus_error}); end
    checks++; if ({ip_readdata, dp_readdata} !== 64'h0) begin failures++; $display("FAIL rst_readdata got=%h exp=0", {ip_readdata, dp_readdata}); end
    read_ip = 0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall_idle got=%b exp=0", stall); end
  endtask

  task automatic test_single_fetch;
    do_reset();
    read_ip = 1; ip_address = 32'hBFC00000; mem_readdata = 32'h3C011234;
    #1;
    checks++; if (mem_read !== 1'b0 || ip_waitrequest !== 1'b1) begin failures++; $display("FAIL fetch_c1 got rd=%b wait=%b exp rd=0 wait=1", mem_read, ip_waitrequest); end
    tick(); #1;
    checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin failures++; $display("FAIL fetch_c2_read got rd=%b wr=%b exp rd=1 wr=0", mem_read, mem_write); end
    checks++; if (mem_address !== 32'hBFC00000 || mem_byteenable !== 4'b1111) begin failures++; $display("FAIL fetch_c2_addr got=%h be=%b exp=bfc00000 be=1111", mem_address, mem_byteenable); end
    checks++; if (ip_waitrequest !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL fetch_c2_wait got=%b stall=%b exp=0", ip_waitrequest, stall); end
    checks++; if (ip_readdata !== 32'h3C011234) begin failures++; $display("FAIL fetch_c2_data got=%h exp=3c011234", ip_readdata); end
    tick();
    read_ip = 0; mem_readdata = 32'h0;
    repeat (2) tick();
    checks++; if (ip_readdata !== 32'h3C011234 || mem_read !== 1'b0) begin failures++; $display("FAIL fetch_hold got=%h rd=%b exp=3c011234 rd=0", ip_readdata, mem_read); end
  endtask

  task automatic test_contention;
    rst = 1;
    clear_inputs();
    read_ip = 1; read_dp = 1; ip_address = 32'h100; dp_address = 32'h200;
    @(posedge clk);
    #1 rst = 0;
    for (int k = 0; k < 8; k++) begin
      mem_readdata = ~mem_address;
      #1;
      if (k % 2 == 0) begin
        checks++; if (ip_waitrequest !== 1'b1 || dp_waitrequest !== 1'b1) begin failures++; $display("FAIL cont_arb_c%0d got ipw=%b dpw=%b exp 1 1", k, ip_waitrequest, dp_waitrequest); end
      end else if (k == 1 || k == 5) begin
        checks++; if (dp_waitrequest !== 1'b0 || ip_waitrequest !== 1'b1) begin failures++; $display("FAIL cont_grant_d_c%0d got ipw=%b dpw=%b exp 1 0", k, ip_waitrequest, dp_waitrequest); end
        checks++; if (dp_readdata !== 32'hFFFFFDFF) begin failures++; $display("FAIL cont_dp_data_c%0d got=%h exp=fffffdff", k, dp_readdata); end
      end else begin
        checks++; if (ip_waitrequest !== 1'b0 || dp_waitrequest !== 1'b1) begin failures++; $display("FAIL cont_grant_i_c%0d got ipw=%b dpw=%b exp 0 1", k, ip_waitrequest, dp_waitrequest); end
        checks++; if (ip_readdata !== 32'hFFFFFEFF) begin failures++; $display("FAIL cont_ip_data_c%0d got=%h exp=fffffeff", k, ip_readdata); end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_byte_write;
    do_reset();
    write_dp = 1; dp_address = 32'h10; writedata = 32'hAABBCCDD; byteenable = 4'b0100;
    mem_waitrequest = 1; mem_readdata = 32'hDEADBEEF;
    #1;
    checks++; if (mem_write !== 1'b0 || dp_waitrequest !== 1'b1) begin failures++; $display("FAIL bw_c1 got wr=%b wait=%b exp wr=0 wait=1", mem_write, dp_waitrequest); end
    for (int c = 2; c <= 4; c++) begin
      tick(); #1;
      checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || dp_waitrequest !== 1'b1) begin failures++; $display("FAIL bw_wait_c%0d got wr=%b rd=%b wait=%b exp 1 0 1", c, mem_write, mem_read, dp_waitrequest); end
      checks++; if (mem_byteenable !== 4'b0100 || mem_address !== 32'h10 || mem_writedata !== 32'hAABBCCDD) begin failures++; $display("FAIL bw_bus_c%0d got be=%b a=%h d=%h", c, mem_byteenable, mem_address, mem_writedata); end
    end
    tick();
    mem_waitrequest = 0;
    #1;
    checks++; if (mem_write !== 1'b1 || dp_waitrequest !== 1'b0) begin failures++; $display("FAIL bw_done got wr=%b wait=%b exp wr=1 wait=0", mem_write, dp_waitrequest); end
    checks++; if (dp_readdata !== 32'h0) begin failures++; $display("FAIL bw_rdata_done got=%h exp=0", dp_readdata); end
    tick();
    write_dp = 0;
    #1;
    checks++; if (mem_write !== 1'b0 || dp_readdata !== 32'h0) begin failures++; $display("FAIL bw_after got wr=%b rdata=%h exp 0 0", mem_write, dp_readdata); end
  endtask

  task automatic test_rw_same;
    read_dp = 1; write_dp = 1; dp_address = 32'h24; writedata = 32'h01020304; byteenable = 4'b1111;
    mem_waitrequest = 0; mem_readdata = 32'hCAFEF00D;
    tick(); #1;
    checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin failures++; $display("FAIL rw_strobes got wr=%b rd=%b exp wr=1 rd=0", mem_write, mem_read); end
    checks++; if (dp_waitrequest !== 1'b0 || dp_readdata !== 32'h0) begin failures++; $display("FAIL rw_done got wait=%b rdata=%h exp 0 0", dp_waitrequest, dp_readdata); end
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout;
    do_reset();
    read_ip = 1; ip_address = 32'h40; mem_waitrequest = 1; mem_readdata = 32'h12345678;
    tick();
    for (int n = 1; n <= 4; n++) begin
      tick(); #1;
      checks++; if (bus_error !== (n == 4)) begin failures++; $display("FAIL to_err_n%0d got=%b exp=%b", n, bus_error, (n == 4)); end
      checks++; if (ip_waitrequest !== 1'b1 || mem_read !== 1'b1) begin failures++; $display("FAIL to_hold_n%0d got wait=%b rd=%b exp 1 1", n, ip_waitrequest, mem_read); end
    end
    tick(); tick();
    mem_waitrequest = 0;
    #1;
    checks++; if (ip_waitrequest !== 1'b0 || ip_readdata !== 32'h12345678) begin failures++; $display("FAIL to_complete got wait=%b data=%h exp 0 12345678", ip_waitrequest, ip_readdata); end
    tick();
    read_ip = 0;
    repeat (3) tick();
    checks++; if (bus_error !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", bus_error); end
  endtask

  // Runs straight after test_timeout so bus_error and ip held data are set.
  task automatic test_async_reset;
    read_dp = 1; dp_address = 32'h20; mem_waitrequest = 0; mem_readdata = 32'h55AA33CC;
    tick(); #1;
    checks++; if (dp_readdata !== 32'h55AA33CC) begin failures++; $display("FAIL ar_pre_read got=%h exp=55aa33cc", dp_readdata); end
    tick();
    read_dp = 0; write_dp = 1; writedata = 32'h9; byteenable = 4'b0001; mem_waitrequest = 1;
    tick(); #1;
    checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL ar_granted got wr=%b exp=1", mem_write); end
    #1 rst = 1;
    #1;
    checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin failures++; $display("FAIL ar_strobes got wr=%b rd=%b exp 0 0", mem_write, mem_read); end
    checks++; if (dp_readdata !== 32'h0 || ip_readdata !== 32'h0) begin failures++; $display("FAIL ar_held got dp=%h ip=%h exp 0 0", dp_readdata, ip_readdata); end
    checks++; if (bus_error !== 1'b0 || dp_waitrequest !== 1'b1) begin failures++; $display("FAIL ar_err_wait got err=%b wait=%b exp 0 1", bus_error, dp_waitrequest); end
    clear_inputs();
    @(posedge clk);
    #1 rst = 0;
    tick(); #1;
    checks++; if (mem_write !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL ar_idle got wr=%b stall=%b exp 0 0", mem_write, stall); end
  endtask

  // Randomized traffic against a transaction-level model: one owner at a time,
  // arbitration on an idle cycle, completion when memory is ready.
  task automatic test_random;
    bit ip_act = 0, dp_act = 0, dp_wr = 0, dp_rd = 0, complete;
    logic [31:0] ip_a = '0, dp_a = '0, dp_wd = '0, held_ip = '0, held_dp = '0, exp_ip, exp_dp;
    logic [3:0] dp_be = '0;
    int owner = 0;      // 0 none, 1 instruction, 2 data
    int last = 1;       // port that completed most recently
    int waits = 0;
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!ip_act && $urandom_range(0, 2) == 0) begin
        ip_act = 1;
        ip_a = ($urandom() & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
      end
      if (!dp_act && $urandom_range(0, 2) == 0) begin
        dp_act = 1;
        dp_wr = 1'($urandom_range(0, 1));
        dp_rd = dp_wr ? 1'($urandom_range(0, 1)) : 1'b1;
        dp_a = ($urandom() & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
        dp_wd = $urandom();
        dp_be = 4'($urandom_range(0, 15));
      end
      read_ip = ip_act; ip_address = ip_a;
      read_dp = dp_act & dp_rd; write_dp = dp_act & dp_wr;
      dp_address = dp_a; writedata = dp_wd; byteenable = dp_be;
      if (owner == 0) mem_waitrequest = 1'($urandom_range(0, 1));
      else mem_waitrequest = (waits < 2) && ($urandom_range(0, 2) == 0);
      #1;
      mem_readdata = mem_model[mem_address[5:2]];
      #1;
      complete = (owner != 0) && !mem_waitrequest;
      exp_ip = (complete && owner == 1) ? mem_model[ip_a[5:2]] : held_ip;
      exp_dp = (complete && owner == 2 && !dp_wr) ? mem_model[dp_a[5:2]] : held_dp;
      checks++; if (ip_waitrequest !== (ip_act && !(complete && owner == 1))) begin failures++; $display("FAIL rnd_ip_wait cyc=%0d got=%b own=%0d", cyc, ip_waitrequest, owner); end
      checks++; if (dp_waitrequest !== (dp_act && !(complete && owner == 2))) begin failures++; $display("FAIL rnd_dp_wait cyc=%0d got=%b own=%0d", cyc, dp_waitrequest, owner); end
      checks++; if (ip_readdata !== exp_ip) begin failures++; $display("FAIL rnd_ip_data cyc=%0d got=%h exp=%h", cyc, ip_readdata, exp_ip); end
      checks++; if (dp_readdata !== exp_dp) begin failures++; $display("FAIL rnd_dp_data cyc=%0d got=%h exp=%h", cyc, dp_readdata, exp_dp); end
      if (owner == 1) begin
        checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== ip_a) begin failures++; $display("FAIL rnd_ibus cyc=%0d got rd=%b wr=%b a=%h exp a=%h", cyc, mem_read, mem_write, mem_address, ip_a); end
      end else if (owner == 2) begin
        checks++; if (mem_read !== !dp_wr || mem_write !== dp_wr || mem_address !== dp_a || mem_byteenable !== dp_be) begin failures++; $display("FAIL rnd_dbus cyc=%0d got rd=%b wr=%b a=%h be=%b exp a=%h be=%b", cyc, mem_read, mem_write, mem_address, mem_byteenable, dp_a, dp_be); end
        if (dp_wr) begin
          checks++; if (mem_writedata !== dp_wd) begin failures++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, mem_writedata, dp_wd); end
        end
      end else begin
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL rnd_idle cyc=%0d got rd=%b wr=%b exp 0 0", cyc, mem_read, mem_write); end
      end
      @(posedge clk);
      if (complete) begin
        if (owner == 1) begin
          held_ip = exp_ip; ip_act = 0;
        end else begin
          if (dp_wr) begin
            for (int b = 0; b < 4; b++)
              if (dp_be[b]) mem_model[dp_a[5:2]][8*b +: 8] = dp_wd[8*b +: 8];
          end else begin
            held_dp = exp_dp;
          end
          dp_act = 0;
        end
        last = owner; owner = 0; waits = 0;
      end else if (owner != 0) begin
        waits++;
      end else if (dp_act && (!ip_act || last == 1)) begin
        owner = 2;
      end else if (ip_act) begin
        owner = 1;
      end
      #1;
    end
    checks++; if (bus_error !== 1'b0) begin failures++; $display("FAIL rnd_bus_error got=%b exp=0", bus_error); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_byte_write();
    test_rw_same();
    test_timeout();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port, Avalon-style unified memory between the CPU instruction-fetch port and data port.
- The CPU-side ports keep the Harvard split: instruction port and data port.
- Each CPU-side port gets a per-port waitrequest and a combined stall output.
- Sits between the CPU core and the unified memory/bus. It arbitrates, sequences one memory transaction at a time, holds read data, and flags memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles a granted transaction may wait on mem_waitrequest before bus_error is raised; 0 disables the check.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- ip_address  in  32  instruction fetch address (byte address, passed through unchanged)
- read_ip  in  1  instruction read request
- ip_readdata  out  32  instruction read data
- ip_waitrequest  out  1  instruction port must hold request
- dp_address  in  32  data address
- writedata  in  32  data write value
- byteenable  in  4  data byte enables
- read_dp  in  1  data read request
- write_dp  in  1  data write request
- dp_readdata  out  32  data read data
- dp_waitrequest  out  1  data port must hold request
- stall  out  1  ip_waitrequest OR dp_waitrequest
- mem_address  out  32  memory address
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_writedata  out  32  memory write data
- mem_byteenable  out  4  memory byte enables
- mem_readdata  in  32  memory read data, valid when mem_waitrequest=0 during mem_read
- mem_waitrequest  in  1  memory not ready
- bus_error  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst=1): FSM to IDLE; mem_read, mem_write, bus_error = 0; held ip/dp readdata registers = 0; last_grant = INSTR; timeout counter = 0. waitrequests remain combinational during reset: asserted iff that port requests.
- Requests: ip_req = read_ip; dp_req = read_dp | write_dp.
  - write_dp=1 with read_dp=1: treated as a write only; the read is dropped.
  - Requesters hold address, data and strobes stable while their waitrequest=1.
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE: no memory strobes. At the clock edge, grant is chosen as follows.
  - Only dp_req: GNT_D.
  - Only ip_req: GNT_I.
  - Both: GNT_D, unless last_grant=DATA, in which case GNT_I (alternation under contention, no starvation).
  - Neither: stay in IDLE.
- GNT_I drives the memory port as follows:
  - mem_address = ip_address
  - mem_read = 1
  - mem_write = 0
  - mem_byteenable = 4'b1111
- GNT_D drives the memory port as follows:
  - mem_address = dp_address
  - mem_byteenable = byteenable
  - mem_writedata = writedata
  - mem_write = write_dp
  - mem_read = read_dp & ~write_dp
- Completion = granted state & mem_waitrequest=0.
  - On the completion edge: last_grant updates, FSM returns to IDLE, timeout counter clears.
  - For reads, mem_readdata is captured into the granted port's held register.
- waitrequest for a port = port requests & not (port granted & completion).
  - Deasserts combinationally in the completion cycle.
  - Minimum latency 2 cycles: 1 arbitration cycle + 1 memory cycle.
  - Throughput: at most one access per 2 cycles.
- Readdata for the granted reading port = mem_readdata during its completion cycle; otherwise the held register. Holds value indefinitely until that port's next completed read. Writes do not change dp_readdata.
- Timeout: counter increments each cycle in GNT_* with mem_waitrequest=1.
  - Reaching TIMEOUT_CYCLES (nonzero) sets bus_error sticky until rst.
  - The transaction continues waiting; it is not aborted.
- Request withdrawn while granted (protocol violation): FSM stays granted, strobes follow the live request inputs. No requirement beyond no X propagation.
- Reset mid-transaction: strobes drop immediately (async); the access is abandoned and held data is cleared.

Test Plan:
- Single fetch: read_ip=1, ip_address=0xBFC00000, memory ready with mem_readdata=0x3C011234 → mem_read high in cycle 2, ip_readdata=0x3C011234, ip_waitrequest low in cycle 2; value held after read_ip drops.
- Contention: read_ip and read_dp both asserted at reset release with zero-wait memory → grant order D, I, D, I; dp_readdata/ip_readdata match their addresses; neither starves.
- Byte write: write_dp=1, dp_address=0x10, writedata=0xAABBCCDD, byteenable=4'b0100, mem_waitrequest=1 for 3 cycles → mem_write held 4 cycles, mem_byteenable=0100, dp_waitrequest low only in final cycle, dp_readdata unchanged.
- Read+write same cycle: read_dp=write_dp=1 → only mem_write asserted; mem_read stays 0.
- Timeout: TIMEOUT_CYCLES=4, mem_waitrequest stuck 1 → bus_error rises after 4 granted wait cycles and stays 1 after the memory later completes; cleared only by rst.
- Async reset mid-access: assert rst between clock edges in GNT_D → mem_write drops before next edge, FSM IDLE, held readdata=0, bus_error=0.
